ps2_keyboard: RTL and testbench
===============================

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 The block SHALL provide parameter DEPTH, default 8, FIFO entry count; it SHALL be a power of two, at least 2.
REQ-002 The block SHALL provide parameter TIMEOUT, default 50000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-003 The block SHALL have port clk, input, 1, system clock; the block has one clock and all state is updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-005 The block SHALL have port ps2_clk, input, 1, raw PS/2 clock, asynchronous to clk.
REQ-006 The block SHALL have port ps2_data, input, 1, raw PS/2 data.
REQ-007 The block SHALL have port nextdata_n, input, 1, active-low pop request.
REQ-008 The block SHALL have port data, output, 8, scan code at the FIFO head.
REQ-009 The block SHALL have port ready, output, 1, high when the FIFO is non-empty.
REQ-010 The block SHALL have port overflow, output, 1, sticky flag: a valid frame was dropped.
REQ-011 The block SHALL have port frame_err, output, 1, one-cycle pulse when a bad frame is discarded.

Function
REQ-012 ps2_clk SHALL pass through a 3-flop synchroniser; a falling edge is detected when sync[2]=1 and sync[1]=0.
REQ-013 On each detected falling edge, ps2_data SHALL be sampled and the 4-bit bit counter SHALL increment.
REQ-014 Frame format SHALL be 11 bits: start=0, data bits D0..D7 LSB first, odd parity, stop=1.
REQ-015 On the 11th falling edge, the frame SHALL be checked; valid means start=0, stop=1, and the XOR of the 8 data bits and the parity bit equals 1.
REQ-016 The bit counter SHALL return to 0 after the 11th edge, whether the frame was valid or not.
REQ-017 A valid frame with the FIFO not full SHALL be written at the write pointer; ready SHALL be high the cycle after the 11th-edge cycle.
REQ-018 A valid frame with the FIFO full and no pop in the same cycle SHALL be dropped and SHALL set overflow to 1.
REQ-019 overflow SHALL stay set until rst.
REQ-020 An invalid frame SHALL be discarded; frame_err SHALL pulse high for exactly the following cycle; FIFO contents SHALL be unchanged.
REQ-021 If the bit counter is non-zero and TIMEOUT cycles elapse with no falling edge, the counter SHALL clear to 0; no write and no frame_err SHALL result.
REQ-022 A pop SHALL occur on every clk cycle where nextdata_n=0 and ready=1; the read pointer advances by 1, modulo DEPTH.
REQ-023 With nextdata_n held low, the FIFO SHALL drain at one entry per cycle.
REQ-024 nextdata_n=0 while ready=0 SHALL be ignored, with no pointer change.
REQ-025 data SHALL be a combinational read of the head entry; when ready=0, data holds the last-read location contents and is don't-care.
REQ-026 Pointers SHALL be log2(DEPTH)+1 bits wide; empty when the pointers are equal; full when the low bits are equal and the MSBs differ; all DEPTH entries are usable.
REQ-027 A push and a pop in the same cycle while full SHALL both succeed, with no overflow set.
REQ-028 A push and a pop in the same cycle while empty SHALL perform only the push, since the pop is ignored.
REQ-029 Scan codes SHALL be stored raw, with no make/break or extended-code (E0/F0) interpretation; that decoding belongs to the downstream ASCII stage.

Reset
REQ-030 With rst=1 at a clk edge, the following SHALL clear: read and write pointers, bit counter, shift register, timeout counter, overflow, and frame_err.
REQ-031 After reset, ready SHALL be 0.
REQ-032 Synchroniser flops SHALL reset to 3'b111, the idle-high line state, so that no false edge occurs after reset.
REQ-033 Reset mid-frame SHALL abandon the partial frame; the next start bit after reset SHALL begin a fresh frame.
REQ-034 FIFO storage SHALL not be cleared by reset; it is unreadable because ready=0.

Verification
REQ-035 Reset, then frame 0x1C (bits 0, 0,0,1,1,1,0,0,0, parity 0, stop 1) -> ready=1 one cycle after the 11th edge, data=0x1C, frame_err never high.
REQ-036 Frame 0x1C with parity bit 1 -> frame_err pulses for 1 cycle, ready stays 0; then frame 0xF0 with parity 1 -> data=0xF0.
REQ-037 DEPTH+1 valid frames 0x01..0x09 with nextdata_n=1 -> overflow=1 after the 9th frame; then nextdata_n low for 8 cycles -> data reads 0x01..0x08 in order, then ready=0.
REQ-038 FIFO full, 9th frame's 11th edge in the same cycle as a pop -> overflow stays 0, 0x09 is retained as the last entry.
REQ-039 6 bits of a frame, then ps2_clk idle for TIMEOUT+10 cycles, then a full frame 0x5A -> data=0x5A, no frame_err, ready=1.
REQ-040 rst asserted for 1 cycle after the 5th bit of a frame, then a full frame 0x29 -> only 0x29 is queued, overflow=0.

Source files
------------

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, assembles 11-bit frames,
// checks start/parity/stop and queues raw scan codes in a small FIFO.
module ps2_keyboard #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow,
   output logic       frame_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]    PTR_ONE = 1;
   localparam logic [TW-1:0]  TMO_ONE = 1;
   localparam logic [TW-1:0]  TMO_MAX = TW'(TIMEOUT - 1);

   logic [2:0]    sync_q, sync_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [9:0]    shift_q, shift_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic          overflow_q, overflow_d;
   logic          frame_err_q, frame_err_d;
   logic [7:0]    mem_q [DEPTH];

   logic          fall, done, valid, empty, full, push, pop;
   logic [10:0]   frame;

   always_comb begin
      sync_d      = {sync_q[1:0], ps2_clk};
      fall        = sync_q[2] & ~sync_q[1];
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      tmo_d       = '0;
      done        = 1'b0;
      // frame[0]=start, [8:1]=D0..D7, [9]=parity, [10]=stop
      frame       = {ps2_data, shift_q};
      valid       = ~frame[0] & frame[10] & (^frame[9:1]);

      if (fall) begin
         shift_d = {ps2_data, shift_q[9:1]};
         if (bit_cnt_q == 4'd10) begin
            bit_cnt_d = 4'd0;
            done      = 1'b1;
         end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end else if (bit_cnt_q != 4'd0) begin
         // A stalled partial frame is abandoned so the next start bit realigns.
         if (tmo_q == TMO_MAX) begin
            bit_cnt_d = 4'd0;
         end else begin
            tmo_d = tmo_q + TMO_ONE;
         end
      end

      empty       = (wr_ptr_q == rd_ptr_q);
      full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) & (wr_ptr_q[AW] != rd_ptr_q[AW]);
      pop         = ~nextdata_n & ~empty;
      push        = done & valid & (~full | pop);
      wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d    = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      overflow_d  = overflow_q | (done & valid & full & ~pop);
      frame_err_d = done & ~valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q      <= 3'b111;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         tmo_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         tmo_q       <= tmo_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Storage is deliberately not reset; ready gates its visibility.
   always_ff @(posedge clk) begin
      if (push && !rst) mem_q[wr_ptr_q[AW-1:0]] <= frame[8:1];
   end

   assign data      = mem_q[rd_ptr_q[AW-1:0]];
   assign ready     = ~empty;
   assign overflow  = overflow_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: bit-banged PS/2 frames with hand-computed expectations.
module tb_ps2_keyboard;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 100;

   logic       clk = 1'b0;
   logic       rst, ps2_clk, ps2_data, nextdata_n;
   logic [7:0] data;
   logic       ready, overflow, frame_err;

   int tests = 0;
   int fails = 0;
   int fe_cnt = 0;
   int fe0;

   ps2_keyboard #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .nextdata_n(nextdata_n), .data(data), .ready(ready),
      .overflow(overflow), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] mk(input logic [7:0] d, input logic bad_par);
      return {1'b1, ~(^d) ^ bad_par, d, 1'b0};
   endfunction

   task automatic drive_bit(input logic b);
      ps2_data = b;
      repeat (4) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (8) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_head(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) drive_bit(f[i]);
   endtask

   // Last bit split in two so the caller can observe the cycles around the 11th edge.
   task automatic last_fall(input logic b);
      ps2_data = b;
      repeat (4) @(negedge clk);
      ps2_clk = 1'b0;
   endtask

   task automatic last_rise();
      repeat (6) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", ready, 0);
      check("rst_overflow", overflow, 0);
      check("rst_frame_err", frame_err, 0);

      // Valid frame 0x1C: ready exactly one cycle after the 11th-edge cycle
      fe0 = fe_cnt;
      send_head(mk(8'h1C, 1'b0), 10);
      last_fall(1'b1);
      @(negedge clk);
      check("1c_rdy_e1", ready, 0);
      @(negedge clk);
      check("1c_rdy_e2", ready, 0);
      @(negedge clk);
      check("1c_ready", ready, 1);
      check("1c_data", data, 32'h1C);
      last_rise();
      check("1c_no_ferr", fe_cnt - fe0, 0);
      nextdata_n = 1'b0;
      @(negedge clk);
      nextdata_n = 1'b1;
      check("1c_popped", ready, 0);
      nextdata_n = 1'b0;
      @(negedge clk);
      nextdata_n = 1'b1;
      check("pop_empty_ignored", ready, 0);

      // Bad parity: single-cycle frame_err, nothing queued
      do_reset();
      fe0 = fe_cnt;
      send_head(mk(8'h1C, 1'b1), 10);
      last_fall(1'b1);
      @(negedge clk);
      @(negedge clk);
      check("bp_ferr_early", frame_err, 0);
      @(negedge clk);
      check("bp_ferr", frame_err, 1);
      check("bp_ready", ready, 0);
      @(negedge clk);
      check("bp_ferr_1cyc", frame_err, 0);
      last_rise();
      check("bp_ferr_cnt", fe_cnt - fe0, 1);
      send_head(mk(8'hF0, 1'b0), 11);
      check("f0_ready", ready, 1);
      check("f0_data", data, 32'hF0);

      // Bad stop bit also discarded
      fe0 = fe_cnt;
      send_head({1'b0, mk(8'h33, 1'b0) & 11'h3FF}, 11);
      check("badstop_ferr", fe_cnt - fe0, 1);
      check("badstop_data", data, 32'hF0);

      // Overflow: DEPTH+1 frames, then drain one per cycle
      do_reset();
      for (int i = 1; i <= DEPTH; i++) send_head(mk(8'(i), 1'b0), 11);
      check("ov_full_noov", overflow, 0);
      send_head(mk(8'h09, 1'b0), 11);
      check("ov_set", overflow, 1);
      nextdata_n = 1'b0;
      for (int i = 1; i <= DEPTH; i++) begin
         check($sformatf("ov_drain%0d", i), {ready, data}, {1'b1, 8'(i)});
         @(negedge clk);
      end
      nextdata_n = 1'b1;
      check("ov_empty", ready, 0);
      check("ov_sticky", overflow, 1);

      // Push on the same cycle as a pop while full
      do_reset();
      for (int i = 1; i <= DEPTH; i++) send_head(mk(8'(i), 1'b0), 11);
      send_head(mk(8'h09, 1'b0), 10);
      last_fall(1'b1);
      @(negedge clk);
      @(negedge clk);
      nextdata_n = 1'b0;
      @(negedge clk);
      nextdata_n = 1'b1;
      last_rise();
      check("pp_noov", overflow, 0);
      nextdata_n = 1'b0;
      for (int i = 2; i <= DEPTH + 1; i++) begin
         check($sformatf("pp_drain%0d", i), {ready, data}, {1'b1, 8'(i)});
         @(negedge clk);
      end
      nextdata_n = 1'b1;
      check("pp_empty", ready, 0);

      // Partial frame abandoned by timeout
      do_reset();
      fe0 = fe_cnt;
      send_head(mk(8'h77, 1'b0), 6);
      repeat (TIMEOUT + 10) @(negedge clk);
      send_head(mk(8'h5A, 1'b0), 11);
      check("to_ready", ready, 1);
      check("to_data", data, 32'h5A);
      check("to_no_ferr", fe_cnt - fe0, 0);

      // Reset mid-frame
      do_reset();
      fe0 = fe_cnt;
      send_head(mk(8'h66, 1'b0), 5);
      do_reset();
      send_head(mk(8'h29, 1'b0), 11);
      check("mr_ready", ready, 1);
      check("mr_data", data, 32'h29);
      check("mr_noov", overflow, 0);
      check("mr_no_ferr", fe_cnt - fe0, 0);
      nextdata_n = 1'b0;
      @(negedge clk);
      nextdata_n = 1'b1;
      check("mr_single", ready, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
